// File: rtl/display7_scan_if.sv
// Bus bundle for the multiplexed 7-segment scanner: shadow-load inputs
// and the registered segment/anode/frame outputs.
interface display7_scan_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] iData;
    logic [DIGITS-1:0]   iBlank;
    logic                iLoad;
    logic [6:0]          oSeg;
    logic [DIGITS-1:0]   oAn;
    logic                oFrame;

    modport master (
        output iData, iBlank, iLoad,
        input  oSeg, oAn, oFrame
    );

    modport slave (
        input  iData, iBlank, iLoad,
        output oSeg, oAn, oFrame
    );
endinterface

// File: rtl/display7_scan.sv
// Multiplexed DIGITS-digit common-anode 7-segment scanner with shadow
// registers and per-digit blanking. Optional macro: LEADING_ZERO_BLANK_EN.
module display7_scan #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input logic             iClk,
    input logic             iRst,
    display7_scan_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] sd;
    logic [DIGITS-1:0]   sb;
    logic [DIGITS-1:0]   lz;
    logic                tick;
    logic [3:0]          nib;
    logic                blank_sel;

    logic [6:0]          seg_p1;
    logic [DIGITS-1:0]   an_p1;
    logic                frame_p1;

    assign tick = (pre == PRE_LAST);

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; digit 0 is never part of the zero run.
    always_comb begin : lz_scan
        logic zero_run;
        zero_run = 1'b1;
        lz = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (sd[4*k +: 4] == 4'h0);
            lz[k] = zero_run;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib = 4'h0;
        blank_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nib = sd[4*k +: 4];
                blank_sel = sb[k] | lz[k];
            end
        end
    end

    // ---- stage p1: scan counters, shadow capture, registered outputs ----
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pre      <= '0;
            idx      <= '0;
            sd       <= '0;
            sb       <= '1;
            seg_p1   <= 7'h7F;
            an_p1    <= '1;
            frame_p1 <= 1'b0;
        end else begin
            if (tick) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            if (bus.iLoad) begin
                sd <= bus.iData;
                sb <= bus.iBlank;
            end
            seg_p1   <= blank_sel ? 7'h7F : dec(nib);
            an_p1    <= ~(DIGITS'(1) << idx);
            frame_p1 <= tick && (idx == IDX_LAST);
        end
    end

    assign bus.oSeg   = seg_p1;
    assign bus.oAn    = an_p1;
    assign bus.oFrame = frame_p1;
endmodule

// File: tb/tb_display7_scan.sv
// Directed, table-driven bench for display7_scan with DIGITS=4, SCAN_DIV=4.
module tb_display7_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nbad = 0;

    display7_scan_if #(.DIGITS(4)) bus ();

    display7_scan #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            ld;
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] seg;
    } vec_t;

    logic [3:0] an_slot [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0][6:0] cur_seg;
    vec_t tbl [6];

    function automatic vec_t mk(input logic ld, input logic [15:0] d, input logic [3:0] b,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        vec_t v;
        v.ld = ld; v.data = d; v.blank = b;
        v.seg = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int i, input logic [3:0] an,
                         input logic [6:0] seg, input logic frame);
        nvec++;
        if (bus.oAn !== an || bus.oSeg !== seg || bus.oFrame !== frame) begin
            nbad++;
            $display("FAIL %s cyc%0d: got an=%b seg=%h frame=%b, want an=%b seg=%h frame=%b",
                     name, i, bus.oAn, bus.oSeg, bus.oFrame, an, seg, frame);
        end
    endtask

    // Starts on an edge where idx=0, pre=0; ends after the frame-wrap edge.
    task automatic run_frame(input string name, input int first);
        for (int i = first; i < 16; i++) begin
            cyc();
            check(name, i, an_slot[i/4], cur_seg[i/4], (i == 15));
        end
    endtask

    // Idle 15 cycles, then load on the wrap edge so alignment is kept.
    task automatic load_frame(input logic [15:0] d, input logic [3:0] b);
        repeat (15) cyc();
        bus.iData = d; bus.iBlank = b; bus.iLoad = 1'b1;
        cyc();
        bus.iLoad = 1'b0;
    endtask

    initial begin
        tbl[0] = mk(1'b1, 16'h8F10, 4'b0000, 7'h40, 7'h79, 7'h0E, 7'h00);
        tbl[1] = mk(1'b1, 16'h8F10, 4'b0100, 7'h40, 7'h79, 7'h7F, 7'h00);
        tbl[2] = mk(1'b0, 16'h1234, 4'b0000, 7'h40, 7'h79, 7'h7F, 7'h00);
`ifdef LEADING_ZERO_BLANK_EN
        tbl[3] = mk(1'b1, 16'h0070, 4'b0000, 7'h40, 7'h78, 7'h7F, 7'h7F);
        tbl[4] = mk(1'b1, 16'h0000, 4'b0000, 7'h40, 7'h7F, 7'h7F, 7'h7F);
`else
        tbl[3] = mk(1'b1, 16'h0070, 4'b0000, 7'h40, 7'h78, 7'h40, 7'h40);
        tbl[4] = mk(1'b1, 16'h0000, 4'b0000, 7'h40, 7'h40, 7'h40, 7'h40);
`endif
        tbl[5] = mk(1'b1, 16'h8F10, 4'b0000, 7'h40, 7'h79, 7'h0E, 7'h00);

        bus.iData = 16'h0; bus.iBlank = 4'h0; bus.iLoad = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        cyc();
        check("reset", 0, 4'b1111, 7'h7F, 1'b0);
        rst = 1'b0;

        cur_seg = {4{7'h7F}};
        run_frame("dark", 0);

        // Park mid-slot on digit 2, then hold reset for three cycles.
        repeat (9) cyc();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("midreset", i, 4'b1111, 7'h7F, 1'b0);
        end
        rst = 1'b0;
        run_frame("dark_walk", 0);

        for (int v = 0; v < 6; v++) begin
            if (tbl[v].ld) begin
                load_frame(tbl[v].data, tbl[v].blank);
            end else begin
                bus.iData = tbl[v].data; bus.iBlank = tbl[v].blank;
            end
            cur_seg = tbl[v].seg;
            run_frame($sformatf("vec%0d", v), 0);
        end

        // Mid-slot load on digit 0: segments switch one edge later, enable steady.
        cyc(); check("tear", 0, 4'b1110, 7'h40, 1'b0);
        cyc(); check("tear", 1, 4'b1110, 7'h40, 1'b0);
        bus.iData = 16'h1235; bus.iBlank = 4'b0000; bus.iLoad = 1'b1;
        cyc(); check("tear", 2, 4'b1110, 7'h40, 1'b0);
        bus.iLoad = 1'b0;
        cyc(); check("tear", 3, 4'b1110, 7'h12, 1'b0);
        cur_seg = {7'h79, 7'h24, 7'h30, 7'h12};
        run_frame("tear_rest", 4);

        // Reset beats a same-cycle load; shadow blank returns to all ones.
        repeat (5) cyc();
        rst = 1'b1; bus.iData = 16'h8F10; bus.iBlank = 4'b0000; bus.iLoad = 1'b1;
        cyc();
        check("rst_load", 0, 4'b1111, 7'h7F, 1'b0);
        rst = 1'b0; bus.iLoad = 1'b0;
        cur_seg = {4{7'h7F}};
        run_frame("post_rst_load", 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
